// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM-style memory stage.
// Holds the access FSM state type and address mapping constants.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    localparam int BASE_ADDR_DEF = 1024;
    localparam int WORD_OFFSET   = 2;

endpackage

// File: rtl/data_memory_sram.sv
// Word-addressed data SRAM for the memory stage.
// Synchronous write port, combinational read on the same address.
module data_memory_sram #(
    parameter int BIT_NUMBER = 32,
    parameter int DEPTH      = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [BIT_NUMBER-1:0]    wdata,
    output logic [BIT_NUMBER-1:0]    rdata
);

    logic [BIT_NUMBER-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_wait.sv
// Memory pipeline stage with a multi-cycle data SRAM access.
// Stalls upstream while an access is in flight, then feeds MEM/WB.
module mem_stage_wait
    import arm_mem_pkg::*;
#(
    parameter int BIT_NUMBER  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [BIT_NUMBER-1:0] alu_result_in,
    input  logic [BIT_NUMBER-1:0] val_rm,
    input  logic [3:0]            dest_in,
    output logic                  freeze,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic [BIT_NUMBER-1:0] alu_result_out,
    output logic [BIT_NUMBER-1:0] mem_data_out,
    output logic [3:0]            dest_out,
    output logic                  addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_t            state;
    logic [CW-1:0]         cnt;
    logic                  mem_op;
    logic                  in_range;
    logic                  busy;
    logic                  commit;
    logic                  we;
    logic [BIT_NUMBER-1:0] idx;
    logic [BIT_NUMBER-1:0] sram_q;
    logic [BIT_NUMBER-1:0] rd;

    assign mem_op   = mem_r_en_in | mem_w_en_in;
    assign idx      = (alu_result_in - BIT_NUMBER'(BASE_ADDR)) >> WORD_OFFSET;
    assign in_range = (alu_result_in >= BIT_NUMBER'(BASE_ADDR)) &&
                      (idx < BIT_NUMBER'(DEPTH));

    // commit marks the cycle whose closing edge retires the op
    always_comb begin
        busy   = 1'b0;
        commit = 1'b0;
        if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    busy   = mem_op;
                    commit = !mem_op || (WAIT_CYCLES == 1);
                end
                ACCESS: begin
                    busy   = 1'b1;
                    commit = (cnt == CNT_LAST);
                end
                default: begin
                    busy   = 1'b0;
                    commit = 1'b0;
                end
            endcase
        end
    end

    assign freeze = busy & rst;
    assign we     = mem_w_en_in & in_range & commit & rst;

    assign rd = !in_range ? '0 :
                (mem_r_en_in & mem_w_en_in) ? val_rm : sram_q;

    data_memory_sram #(
        .BIT_NUMBER(BIT_NUMBER),
        .DEPTH     (DEPTH)
    ) u_sram (
        .clk  (clk),
        .we   (we),
        .addr (idx[AW-1:0]),
        .wdata(val_rm),
        .rdata(sram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && WAIT_CYCLES > 1) begin
                        state <= ACCESS;
                        cnt   <= CW'(1);
                    end else if (mem_op && WAIT_CYCLES == 1) begin
                        state <= DONE;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // non-committing cycles insert a bubble that keeps the data fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out      <= 1'b0;
            mem_r_en_out   <= 1'b0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
            dest_out       <= '0;
            addr_err       <= 1'b0;
        end else if (commit) begin
            wb_en_out      <= wb_en_in;
            mem_r_en_out   <= mem_r_en_in;
            alu_result_out <= alu_result_in;
            mem_data_out   <= rd;
            dest_out       <= dest_in;
            addr_err       <= mem_op & ~in_range;
        end else begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            addr_err     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_wait.sv
// Bench for mem_stage_wait: directed scenarios plus a randomized
// op stream checked against a cycle-level behavioural model.
module tb_mem_stage_wait;

    localparam int W    = 3;
    localparam int D    = 64;
    localparam int BASE = 1024;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        err;
        logic [3:0]  dst;
        logic [31:0] alu;
        logic [31:0] md;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en_in = 1'b0;
    logic        mem_r_en_in = 1'b0;
    logic        mem_w_en_in = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] val_rm = '0;
    logic [3:0]  dest_in = '0;
    logic        freeze;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic [3:0]  dest_out;
    logic        addr_err;

    int    tests = 0;
    int    fails = 0;
    logic  fz[$];
    snap_t ob[$];
    logic [31:0] mem_m [D];

    always #5 clk = ~clk;

    mem_stage_wait #(
        .BIT_NUMBER (32),
        .DEPTH      (D),
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en_in      (wb_en_in),
        .mem_r_en_in   (mem_r_en_in),
        .mem_w_en_in   (mem_w_en_in),
        .alu_result_in (alu_result_in),
        .val_rm        (val_rm),
        .dest_in       (dest_in),
        .freeze        (freeze),
        .wb_en_out     (wb_en_out),
        .mem_r_en_out  (mem_r_en_out),
        .alu_result_out(alu_result_out),
        .mem_data_out  (mem_data_out),
        .dest_out      (dest_out),
        .addr_err      (addr_err)
    );

    function automatic snap_t cur();
        return {wb_en_out, mem_r_en_out, addr_err, dest_out,
                alu_result_out, mem_data_out};
    endfunction

    function automatic snap_t bub(snap_t p);
        snap_t q = p;
        q.wb = 1'b0;
        q.mr = 1'b0;
        q.err = 1'b0;
        return q;
    endfunction

    // Present one op and hold it until upstream would advance;
    // fz[k] is freeze in cycle k, ob[k] the outputs after edge k.
    task automatic do_op(input logic wb, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] d);
        int n;
        n = (r | w) ? W + 1 : 1;
        fz.delete();
        ob.delete();
        wb_en_in = wb;
        mem_r_en_in = r;
        mem_w_en_in = w;
        alu_result_in = a;
        val_rm = v;
        dest_in = d;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            fz.push_back(freeze);
            @(posedge clk);
            #1;
            ob.push_back(cur());
        end
    endtask

    task automatic set_idle();
        wb_en_in = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_result_in = '0;
        val_rm = '0;
        dest_in = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        mem_w_en_in = 1'b1;
        alu_result_in = 32'd1028;
        val_rm = 32'h1111_2222;
        repeat (2) @(negedge clk);
        tests++;
        if (freeze !== 1'b0)
            $display("FAIL reset_freeze: got %b want 0", freeze);
        if (freeze !== 1'b0) fails++;
        tests++;
        if (cur() !== '0) begin
            $display("FAIL reset_outputs: got %h want 0", cur());
            fails++;
        end
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        logic [31:0] v;
        for (int i = 0; i < D; i++) begin
            v = $urandom;
            do_op(1'b0, 1'b0, 1'b1,
                  32'(BASE + 4 * i + $urandom_range(0, 3)), v, 4'(i));
            mem_m[i] = v;
            for (int k = 0; k <= W; k++) begin
                tests++;
                if (fz[k] !== logic'(k < W)) begin
                    $display("FAIL fill_freeze[%0d/%0d]: got %b want %b",
                             i, k, fz[k], k < W);
                    fails++;
                end
            end
        end
    endtask

    task automatic test_write_read();
        do_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd1);
        mem_m[1] = 32'hDEAD_BEEF;
        for (int k = 0; k <= W; k++) begin
            tests++;
            if (fz[k] !== logic'(k < 3) || ob[k].wb !== 1'b0) begin
                $display("FAIL wr_cycle%0d: got fz=%b wb=%b want fz=%b wb=0",
                         k, fz[k], ob[k].wb, k < 3);
                fails++;
            end
        end
        do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (ob[k].wb !== 1'b0 || ob[k].mr !== 1'b0) begin
                $display("FAIL rd_bubble%0d: got wb=%b mr=%b want 0 0",
                         k + 1, ob[k].wb, ob[k].mr);
                fails++;
            end
        end
        tests++;
        if (ob[2].md !== 32'hDEAD_BEEF || ob[2].mr !== 1'b1 ||
            ob[2].wb !== 1'b1 || ob[2].dst !== 4'd5) begin
            $display("FAIL rd_data: got md=%h mr=%b wb=%b dst=%0d want deadbeef 1 1 5",
                     ob[2].md, ob[2].mr, ob[2].wb, ob[2].dst);
            fails++;
        end
    endtask

    task automatic test_alu();
        snap_t e;
        e = {1'b1, 1'b0, 1'b0, 4'd7, 32'h55, 32'h0};
        do_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd7);
        tests++;
        if (fz[0] !== 1'b0 || ob[0] !== e) begin
            $display("FAIL alu_op: got fz=%b out=%h want fz=0 out=%h",
                     fz[0], ob[0], e);
            fails++;
        end
    endtask

    task automatic test_oob();
        do_op(1'b0, 1'b0, 1'b1, 32'd1280, 32'hA5A5_A5A5, 4'd3);
        tests++;
        if (ob[2].err !== 1'b1 || fz[2] !== 1'b1 || fz[3] !== 1'b0) begin
            $display("FAIL oob_write: got err=%b fz2=%b fz3=%b want 1 1 0",
                     ob[2].err, fz[2], fz[3]);
            fails++;
        end
        do_op(1'b1, 1'b1, 1'b0, 32'd1280, 32'h0, 4'd4);
        tests++;
        if (ob[2].md !== 32'h0 || ob[2].err !== 1'b1) begin
            $display("FAIL oob_read: got md=%h err=%b want 0 1",
                     ob[2].md, ob[2].err);
            fails++;
        end
        do_op(1'b0, 1'b0, 1'b1, 32'd1020, 32'h5A5A_5A5A, 4'd4);
        tests++;
        if (ob[2].err !== 1'b1) begin
            $display("FAIL below_base: got err=%b want 1", ob[2].err);
            fails++;
        end
        do_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd6);
        tests++;
        if (ob[2].md !== mem_m[0] || ob[2].err !== 1'b0) begin
            $display("FAIL oob_word0: got md=%h err=%b want %h 0",
                     ob[2].md, ob[2].err, mem_m[0]);
            fails++;
        end
        do_op(1'b1, 1'b1, 1'b0, 32'd1276, 32'h0, 4'd6);
        tests++;
        if (ob[2].md !== mem_m[63]) begin
            $display("FAIL oob_word63: got %h want %h", ob[2].md, mem_m[63]);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        wb_en_in = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b1;
        alu_result_in = 32'd1032;
        val_rm = 32'h0BAD_F00D;
        dest_in = 4'd2;
        @(posedge clk);
        #1;
        tests++;
        if (freeze !== 1'b1) begin
            $display("FAIL mid_freeze_pre: got %b want 1", freeze);
            fails++;
        end
        rst = 1'b0;
        #1;
        tests++;
        if (freeze !== 1'b0 || cur() !== '0) begin
            $display("FAIL mid_reset_out: got fz=%b out=%h want 0 0",
                     freeze, cur());
            fails++;
        end
        @(posedge clk);
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8);
        tests++;
        if (ob[2].md !== mem_m[2] || ob[2].mr !== 1'b1 ||
            fz[2] !== 1'b1 || fz[3] !== 1'b0) begin
            $display("FAIL mid_after: got md=%h mr=%b want %h 1",
                     ob[2].md, ob[2].mr, mem_m[2]);
            fails++;
        end
    endtask

    task automatic test_rw_same();
        do_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h12, 4'd9);
        mem_m[3] = 32'h12;
        tests++;
        if (ob[2].md !== 32'h12 || ob[2].err !== 1'b0) begin
            $display("FAIL rw_data: got md=%h err=%b want 12 0",
                     ob[2].md, ob[2].err);
            fails++;
        end
        do_op(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd9);
        tests++;
        if (ob[2].md !== 32'h12) begin
            $display("FAIL rw_word3: got %h want 12", ob[2].md);
            fails++;
        end
    endtask

    task automatic test_random();
        snap_t prev;
        snap_t c;
        snap_t e;
        logic  r, w, wb, in_r;
        logic [31:0] a, v;
        logic [3:0]  d;
        int typ, sel, idx;
        prev = '0;
        for (int i = 0; i < 60; i++) begin
            typ = (i == 0) ? 0 : $urandom_range(0, 3);
            r = (typ == 1 || typ == 3);
            w = (typ >= 2);
            wb = 1'($urandom);
            d = 4'($urandom);
            v = $urandom;
            sel = $urandom_range(0, 7);
            if (sel < 6)
                a = 32'(BASE + 4 * $urandom_range(0, D - 1) + $urandom_range(0, 3));
            else if (sel == 6)
                a = 32'($urandom_range(0, BASE - 1));
            else
                a = 32'(BASE + 4 * D + $urandom_range(0, 4095));
            in_r = (a >= BASE) && ((a - BASE) / 4 < D);
            idx = in_r ? int'((a - BASE) / 4) : 0;
            c.wb = wb;
            c.mr = r;
            c.err = (r | w) & ~in_r;
            c.dst = d;
            c.alu = a;
            c.md = !in_r ? 32'h0 : (r && w) ? v : mem_m[idx];
            do_op(wb, r, w, a, v, d);
            for (int k = 0; k < fz.size(); k++) begin
                if (!(r | w)) e = c;
                else if (k < W - 1) e = bub(prev);
                else if (k == W - 1) e = c;
                else e = bub(c);
                tests++;
                if (fz[k] !== logic'((r | w) && k < W) || ob[k] !== e) begin
                    $display("FAIL rand[%0d].c%0d: got fz=%b out=%h want fz=%b out=%h",
                             i, k, fz[k], ob[k], (r | w) && k < W, e);
                    fails++;
                end
            end
            if (w && in_r) mem_m[idx] = v;
            prev = (r | w) ? bub(c) : c;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_alu();
        test_oob();
        test_reset_mid();
        test_rw_same();
        test_random();
        set_idle();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
